// File: rtl/axi_to_lpi_slave_bridge.sv
// AXI slave to LPI master bridge: replays every AXI burst beat as one
// single-word LPI request, one transaction in flight at a time.
// Optional feature: define AXI2LPI_WRAP_BURST_EN to honour WRAP bursts;
// without it WRAP bursts step like INCR and no wrap logic is built.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbitrate AW vs AR, capture burst parameters on handshake
// WR_Q  | W beats flow straight through to LPI write requests
// WR_B  | hold write response until accepted
// RD_Q  | issue one LPI read request for the current beat
// RD_Y  | wait for the LPI read reply
// RD_R  | present registered read data on R until accepted
module axi_to_lpi_slave_bridge #(
    parameter int BW_ADDR = 32,
    parameter int BW_DATA = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BW_ADDR-1:0]   rxawaddr,
    input  logic [7:0]           rxawlen,
    input  logic [1:0]           rxawburst,
    input  logic                 rxawvalid,
    output logic                 rxawready,
    input  logic [BW_DATA-1:0]   rxwdata,
    input  logic [BW_DATA/8-1:0] rxwstrb,
    input  logic                 rxwvalid,
    output logic                 rxwready,
    output logic                 rxbvalid,
    input  logic                 rxbready,
    input  logic [BW_ADDR-1:0]   rxaraddr,
    input  logic [7:0]           rxarlen,
    input  logic [1:0]           rxarburst,
    input  logic                 rxarvalid,
    output logic                 rxarready,
    output logic [BW_DATA-1:0]   rxrdata,
    output logic                 rxrlast,
    output logic                 rxrvalid,
    input  logic                 rxrready,
    output logic                 lpi_qvalid,
    input  logic                 lpi_qready,
    output logic                 lpi_qwrite,
    output logic [BW_ADDR-1:0]   lpi_qaddr,
    output logic [BW_DATA-1:0]   lpi_qwdata,
    output logic [BW_DATA/8-1:0] lpi_qstrb,
    input  logic                 lpi_yvalid,
    input  logic [BW_DATA-1:0]   lpi_ydata
);

    localparam int NB = BW_DATA / 8;
    localparam logic [BW_ADDR-1:0] NB_A       = BW_ADDR'(NB);
    localparam logic [BW_ADDR-1:0] ALIGN_MASK = ~BW_ADDR'(NB - 1);

    typedef enum logic [2:0] {IDLE, WR_Q, WR_B, RD_Q, RD_Y, RD_R} state_t;

    state_t             state, state_nx;
    logic               wr_prio;
    logic [BW_ADDR-1:0] addr_q, addr_nx;
    logic [7:0]         len_q, cnt_q;
    logic [1:0]         burst_q;
    logic [BW_DATA-1:0] rdata_q;
    logic               grant_wr, grant_rd, last_beat;
    logic               aw_hs, ar_hs, w_hs, r_hs;

    // With both requests pending, the priority pointer picks the winner
    assign grant_wr  = rxawvalid & (~rxarvalid | wr_prio);
    assign grant_rd  = rxarvalid & (~rxawvalid | ~wr_prio);
    assign last_beat = (cnt_q == len_q);

    assign aw_hs = rxawvalid & rxawready;
    assign ar_hs = rxarvalid & rxarready;
    assign w_hs  = rxwvalid & rxwready;
    assign r_hs  = rxrvalid & rxrready;

    assign lpi_qaddr  = addr_q;
    assign lpi_qwdata = rxwdata;
    assign rxrdata    = rdata_q;

`ifdef AXI2LPI_WRAP_BURST_EN
    logic [BW_ADDR-1:0] wrap_mask;
    logic               wrap_ok;

    // Next beat address; WRAP only wraps for 2/4/8/16-beat bursts
    always_comb begin
        wrap_ok   = (burst_q == 2'b10) &&
                    (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
        wrap_mask = BW_ADDR'((int'(len_q) + 1) * NB - 1);
        addr_nx   = addr_q + NB_A;
        if (burst_q == 2'b00)
            addr_nx = addr_q;
        else if (wrap_ok)
            addr_nx = (addr_q & ~wrap_mask) | ((addr_q + NB_A) & wrap_mask);
    end
`else
    // Next beat address; FIXED holds, everything else increments
    always_comb begin
        addr_nx = addr_q + NB_A;
        if (burst_q == 2'b00)
            addr_nx = addr_q;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and handshake outputs; everything idles while in reset
    always_comb begin
        state_nx   = state;
        rxawready  = 1'b0;
        rxarready  = 1'b0;
        rxwready   = 1'b0;
        rxbvalid   = 1'b0;
        rxrvalid   = 1'b0;
        rxrlast    = 1'b0;
        lpi_qvalid = 1'b0;
        lpi_qwrite = 1'b0;
        lpi_qstrb  = '1;
        if (!rst) begin
            case (state)
                IDLE: begin
                    rxawready = grant_wr;
                    rxarready = grant_rd;
                    if (grant_wr)
                        state_nx = WR_Q;
                    else if (grant_rd)
                        state_nx = RD_Q;
                end
                WR_Q: begin
                    lpi_qvalid = rxwvalid;
                    rxwready   = lpi_qready;
                    lpi_qwrite = 1'b1;
                    lpi_qstrb  = rxwstrb;
                    if (rxwvalid && lpi_qready && last_beat)
                        state_nx = WR_B;
                end
                WR_B: begin
                    rxbvalid = 1'b1;
                    if (rxbready)
                        state_nx = IDLE;
                end
                RD_Q: begin
                    lpi_qvalid = 1'b1;
                    if (lpi_qready)
                        state_nx = RD_Y;
                end
                RD_Y: begin
                    if (lpi_yvalid)
                        state_nx = RD_R;
                end
                RD_R: begin
                    rxrvalid = 1'b1;
                    rxrlast  = last_beat;
                    if (rxrready)
                        state_nx = last_beat ? IDLE : RD_Q;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Burst bookkeeping: capture on grant, advance on every completed beat
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prio <= 1'b1;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (aw_hs) begin
                wr_prio <= ~wr_prio;
                addr_q  <= rxawaddr & ALIGN_MASK;
                len_q   <= rxawlen;
                burst_q <= rxawburst;
                cnt_q   <= '0;
            end else if (ar_hs) begin
                wr_prio <= ~wr_prio;
                addr_q  <= rxaraddr & ALIGN_MASK;
                len_q   <= rxarlen;
                burst_q <= rxarburst;
                cnt_q   <= '0;
            end else if (w_hs || r_hs) begin
                addr_q <= addr_nx;
                cnt_q  <= cnt_q + 8'd1;
            end
            if (state == RD_Y && lpi_yvalid)
                rdata_q <= lpi_ydata;
        end
    end

endmodule
